// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, size encodings and the data-access legality rule for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Misaligned or unsupported data access: size 3, odd half, unaligned word.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_WORD: bad = (offset != 2'd0);
            SZ_HALF: bad = offset[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side fetch/data ports and memory-side port of the arbiter, bundled as one interface.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic [31:0]       ifRdata;
    logic              ifDone;
    logic              ifErr;

    logic              dReq;
    logic              dWe;
    logic [ADDR_W-1:0] dAddr;
    logic [31:0]       dWdata;
    logic [1:0]        dSize;
    logic [31:0]       dRdata;
    logic [1:0]        dOffset;
    logic [1:0]        dSizeQ;
    logic              dDone;
    logic              dErr;

    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [3:0]        memBe;
    logic [31:0]       memRdata;
    logic              memAck;

    logic              stall;

    modport slave (
        input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, dSize, memRdata, memAck,
        output ifRdata, ifDone, ifErr, dRdata, dOffset, dSizeQ, dDone, dErr,
        output memReq, memWe, memAddr, memWdata, memBe, stall
    );

    modport master (
        output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, dSize, memRdata, memAck,
        input  ifRdata, ifDone, ifErr, dRdata, dOffset, dSizeQ, dDone, dErr,
        input  memReq, memWe, memAddr, memWdata, memBe, stall
    );

endinterface

// File: rtl/mem_port_arbiter_store_lane_formatter.sv
// Big-endian byte-lane placement and byte enables for a store of the given size/offset.
module store_lane_formatter
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be_c,
    output logic [31:0] o_lane_data_c
);

    // Replicate the right-justified datum across lanes; enables select the addressed lanes.
    always_comb begin
        o_be_c        = 4'b0000;
        o_lane_data_c = i_wdata;
        case (i_size)
            SZ_WORD: o_be_c = 4'b1111;
            SZ_HALF: begin
                o_be_c        = i_offset[1] ? 4'b0011 : 4'b1100;
                o_lane_data_c = {2{i_wdata[15:0]}};
            end
            SZ_BYTE: begin
                o_be_c        = 4'b1000 >> i_offset;
                o_lane_data_c = {4{i_wdata[7:0]}};
            end
            default: o_be_c = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-ported memory with ack timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = 8;

    state_t             r_state;
    state_t             w_state_nxt;
    grant_t             r_last_grant;
    logic [CNT_W-1:0]   r_wait;

    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_be;
    logic [31:0]        r_if_rdata;
    logic [31:0]        r_d_rdata;
    logic [1:0]         r_d_offset;
    logic [1:0]         r_d_size_q;
    logic               r_if_done;
    logic               r_if_err;
    logic               r_d_done;
    logic               r_d_err;

    logic               w_if_req;
    logic               w_d_req;
    logic               w_d_illegal;
    logic               w_conflict;
    logic               w_gnt_fetch;
    logic               w_gnt_data;
    logic               w_ack_take;
    logic               w_timeout;
    logic [3:0]         w_lane_be;
    logic [31:0]        w_lane_data;
    logic               w_unused_if_lsb;

    store_lane_formatter u_lane_fmt (
        .i_size        (bus.dSize),
        .i_offset      (bus.dAddr[1:0]),
        .i_wdata       (bus.dWdata),
        .o_be_c        (w_lane_be),
        .o_lane_data_c (w_lane_data)
    );

    // A request whose error is pulsing this cycle is already answered; do not re-grant it.
    assign w_if_req        = bus.ifReq & ~r_if_err;
    assign w_d_req         = bus.dReq & ~r_d_err;
    assign w_d_illegal     = is_illegal(bus.dSize, bus.dAddr[1:0]);
    assign w_unused_if_lsb = ^bus.ifAddr[1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, grant decision and ack/timeout detection.
    always_comb begin
        w_state_nxt = r_state;
        w_conflict  = 1'b0;
        w_gnt_fetch = 1'b0;
        w_gnt_data  = 1'b0;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_conflict = w_if_req & w_d_req;
                if (w_conflict) begin
                    if (r_last_grant == GNT_FETCH) w_gnt_data  = 1'b1;
                    else                           w_gnt_fetch = 1'b1;
                end else if (w_d_req) begin
                    w_gnt_data = 1'b1;
                end else if (w_if_req) begin
                    w_gnt_fetch = 1'b1;
                end
                if (w_gnt_fetch)                    w_state_nxt = ST_FETCH;
                else if (w_gnt_data && !w_d_illegal) w_state_nxt = ST_DATA;
            end
            ST_FETCH, ST_DATA: begin
                if (bus.memAck) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (r_wait == CNT_W'(MAX_WAIT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory command, wait counter, response data and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GNT_FETCH;
            r_wait       <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_d_offset   <= '0;
            r_d_size_q   <= '0;
            r_if_done    <= 1'b0;
            r_if_err     <= 1'b0;
            r_d_done     <= 1'b0;
            r_d_err      <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_if_err  <= 1'b0;
            r_d_done  <= 1'b0;
            r_d_err   <= 1'b0;
            if (w_conflict) r_last_grant <= w_gnt_data ? GNT_DATA : GNT_FETCH;
            if (r_mem_req && !bus.memAck) r_wait <= r_wait + CNT_W'(1);
            if (w_gnt_fetch) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= {bus.ifAddr[ADDR_W-1:2], 2'b00};
                r_mem_wdata <= '0;
                r_mem_be    <= 4'b1111;
                r_wait      <= '0;
            end
            if (w_gnt_data) begin
                r_d_offset <= bus.dAddr[1:0];
                r_d_size_q <= bus.dSize;
                if (w_d_illegal) begin
                    r_d_err <= 1'b1;
                end else begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= bus.dWe;
                    r_mem_addr  <= {bus.dAddr[ADDR_W-1:2], 2'b00};
                    r_mem_wdata <= w_lane_data;
                    r_mem_be    <= w_lane_be;
                    r_wait      <= '0;
                end
            end
            if (w_ack_take) begin
                r_mem_req <= 1'b0;
                if (r_state == ST_FETCH) begin
                    r_if_rdata <= bus.memRdata;
                    r_if_done  <= 1'b1;
                end else begin
                    r_d_rdata <= bus.memRdata;
                    r_d_done  <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_mem_req <= 1'b0;
                if (r_state == ST_FETCH) r_if_err <= 1'b1;
                else                     r_d_err  <= 1'b1;
            end
        end
    end

    assign bus.memReq   = r_mem_req;
    assign bus.memWe    = r_mem_we;
    assign bus.memAddr  = r_mem_addr;
    assign bus.memWdata = r_mem_wdata;
    assign bus.memBe    = r_mem_be;
    assign bus.ifRdata  = r_if_rdata;
    assign bus.ifDone   = r_if_done;
    assign bus.ifErr    = r_if_err;
    assign bus.dRdata   = r_d_rdata;
    assign bus.dOffset  = r_d_offset;
    assign bus.dSizeQ   = r_d_size_q;
    assign bus.dDone    = r_d_done;
    assign bus.dErr     = r_d_err;
    assign bus.stall    = (bus.ifReq & ~(r_if_done | r_if_err)) |
                          (bus.dReq  & ~(r_d_done  | r_d_err));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level expectation model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Expected memory command of the transaction currently owning the memory.
    logic        exp_valid = 1'b0;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    // Literal command pinned by hand for one transaction.
    logic        lit_en = 1'b0;
    logic [31:0] lit_addr;
    logic [3:0]  lit_be;
    logic [31:0] lit_wdata;
    logic        prev_d_done = 1'b0;
    logic        prev_if_done = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Byte lane k (0 = bits 31:24) is enabled when it lies inside [offset, offset+nbytes).
    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
        int nb;
        logic [3:0] be;
        be = '0;
        nb = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        for (int i = 0; i < 4; i++)
            if (i >= int'(off) && i < int'(off) + nb) be[3-i] = 1'b1;
        return be;
    endfunction

    // Lane k carries datum byte ((3-k) mod nbytes): the datum repeated across the word.
    function automatic logic [31:0] model_lanes(input logic [31:0] w, input logic [1:0] size);
        int nb;
        logic [31:0] r;
        r  = '0;
        nb = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
        for (int i = 0; i < 4; i++) r[(3-i)*8 +: 8] = w[((3-i) % nb)*8 +: 8];
        return r;
    endfunction

    task automatic set_expect(input bit is_fetch, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size);
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_we    = is_fetch ? 1'b0 : we;
        exp_be    = is_fetch ? 4'b1111 : model_be(size, addr[1:0]);
        exp_wdata = model_lanes(wdata, size);
        exp_valid = 1'b1;
    endtask

    // Per-cycle compare of the memory command, stall and pulse widths.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (bus.memReq) begin
                if (!exp_valid) begin
                    chk("unexpected memReq", 32'(bus.memReq), 32'd0);
                end else begin
                    chk("memAddr", bus.memAddr, exp_addr);
                    chk("memWe", 32'(bus.memWe), 32'(exp_we));
                    chk("memBe", 32'(bus.memBe), 32'(exp_be));
                    if (exp_we) chk("memWdata", bus.memWdata, exp_wdata);
                end
                if (lit_en) begin
                    chk("lit memAddr", bus.memAddr, lit_addr);
                    chk("lit memBe", 32'(bus.memBe), 32'(lit_be));
                    chk("lit memWdata", bus.memWdata, lit_wdata);
                end
            end
            chk("stall", 32'(bus.stall),
                32'((bus.ifReq && !(bus.ifDone || bus.ifErr)) || (bus.dReq && !(bus.dDone || bus.dErr))));
            if (bus.dDone && prev_d_done)   chk("dDone width", 32'd2, 32'd1);
            if (bus.ifDone && prev_if_done) chk("ifDone width", 32'd2, 32'd1);
        end
        prev_d_done  = bus.dDone;
        prev_if_done = bus.ifDone;
    end

    // With the request already driven and the expectation set: wait for memReq, ack after k cycles, check done.
    task automatic serve(input string nm, input bit is_fetch, input int k, input logic [31:0] rdata,
                         input logic [1:0] off, input logic [1:0] sz);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.memReq && n < 10);
        chk({nm, " grant latency"}, 32'(n), 32'd1);
        if (bus.memReq) begin
            for (int i = 0; i < k; i++) begin
                @(negedge clk);
                chk({nm, " memReq held"}, 32'(bus.memReq), 32'd1);
            end
            bus.memAck   = 1'b1;
            bus.memRdata = rdata;
            @(negedge clk);
            bus.memAck   = 1'b0;
            bus.memRdata = 32'hDEAD_BEEF;
            chk({nm, " memReq dropped"}, 32'(bus.memReq), 32'd0);
            if (is_fetch) begin
                chk({nm, " ifDone"}, 32'(bus.ifDone), 32'd1);
                chk({nm, " ifRdata"}, bus.ifRdata, rdata);
                chk({nm, " dDone"}, 32'(bus.dDone), 32'd0);
            end else begin
                chk({nm, " dDone"}, 32'(bus.dDone), 32'd1);
                chk({nm, " dErr"}, 32'(bus.dErr), 32'd0);
                chk({nm, " dRdata"}, bus.dRdata, rdata);
                chk({nm, " dOffset"}, 32'(bus.dOffset), 32'(off));
                chk({nm, " dSizeQ"}, 32'(bus.dSizeQ), 32'(sz));
                chk({nm, " ifDone"}, 32'(bus.ifDone), 32'd0);
            end
        end
        exp_valid = 1'b0;
        if (is_fetch) bus.ifReq = 1'b0;
        else          bus.dReq  = 1'b0;
        @(negedge clk);
        chk({nm, " done cleared"}, 32'(bus.ifDone | bus.dDone), 32'd0);
    endtask

    task automatic run_data(input string nm, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input int k,
                            input logic [31:0] rdata);
        set_expect(1'b0, we, addr, wdata, size);
        bus.dReq = 1'b1; bus.dWe = we; bus.dAddr = addr; bus.dWdata = wdata; bus.dSize = size;
        serve(nm, 1'b0, k, rdata, addr[1:0], size);
    endtask

    task automatic run_illegal(input string nm, input logic [31:0] addr, input logic [1:0] size);
        exp_valid = 1'b0;
        bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = addr; bus.dWdata = 32'h5555_AAAA; bus.dSize = size;
        @(negedge clk);
        chk({nm, " dErr"}, 32'(bus.dErr), 32'd1);
        chk({nm, " dDone"}, 32'(bus.dDone), 32'd0);
        chk({nm, " dOffset"}, 32'(bus.dOffset), 32'(addr[1:0]));
        chk({nm, " dSizeQ"}, 32'(bus.dSizeQ), 32'(size));
        bus.dReq = 1'b0;
        @(negedge clk);
        chk({nm, " dErr cleared"}, 32'(bus.dErr), 32'd0);
        chk({nm, " no memReq"}, 32'(bus.memReq), 32'd0);
    endtask

    // Both ports request together; the expected winner is served first, then the other.
    task automatic run_conflict(input string nm, input bit data_first);
        bus.ifReq = 1'b1; bus.ifAddr = 32'h0000_4006;
        bus.dReq = 1'b1; bus.dWe = 1'b0; bus.dAddr = 32'h0000_5008; bus.dSize = 2'd0; bus.dWdata = '0;
        if (data_first) begin
            set_expect(1'b0, 1'b0, 32'h0000_5008, '0, 2'd0);
            serve({nm, " data"}, 1'b0, 0, 32'hD0D0_0001, 2'd0, 2'd0);
            set_expect(1'b1, 1'b0, 32'h0000_4006, '0, 2'd0);
            serve({nm, " fetch"}, 1'b1, 1, 32'hF0F0_0002, 2'd0, 2'd0);
        end else begin
            set_expect(1'b1, 1'b0, 32'h0000_4006, '0, 2'd0);
            serve({nm, " fetch"}, 1'b1, 0, 32'hF0F0_0003, 2'd0, 2'd0);
            set_expect(1'b0, 1'b0, 32'h0000_5008, '0, 2'd0);
            serve({nm, " data"}, 1'b0, 1, 32'hD0D0_0004, 2'd0, 2'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.ifReq = 0; bus.ifAddr = '0; bus.dReq = 0; bus.dWe = 0; bus.dAddr = '0;
        bus.dWdata = '0; bus.dSize = '0; bus.memRdata = '0; bus.memAck = 0;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset memReq", 32'(bus.memReq), 32'd0);
        chk("reset memAddr", bus.memAddr, 32'd0);
        chk("reset memBe", 32'(bus.memBe), 32'd0);
        chk("reset pulses", 32'({bus.ifDone, bus.ifErr, bus.dDone, bus.dErr}), 32'd0);
        chk("reset dOffset/dSizeQ", 32'({bus.dOffset, bus.dSizeQ}), 32'd0);
        chk("reset rdata", bus.ifRdata | bus.dRdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Alternation on conflicts: data, then fetch, then data.
        run_conflict("conflict1", 1'b1);
        run_conflict("conflict2", 1'b0);
        run_conflict("conflict3", 1'b1);

        // Store byte at offset 2 with hand-computed command.
        lit_addr = 32'h0000_1000; lit_be = 4'b0010; lit_wdata = 32'hABAB_ABAB; lit_en = 1'b1;
        run_data("st byte", 1'b1, 32'h0000_1002, 32'h0000_00AB, 2'd2, 2, 32'h0);
        lit_en = 1'b0;

        run_data("ld half", 1'b0, 32'h0000_2002, 32'h0, 2'd1, 0, 32'h1234_ABCD);
        run_data("st half0", 1'b1, 32'h0000_2100, 32'hFFFF_BEEF, 2'd1, 1, 32'h0);
        run_data("st word", 1'b1, 32'h0000_2204, 32'hCAFE_F00D, 2'd0, 3, 32'h0);
        run_data("st byte0", 1'b1, 32'h0000_2300, 32'h0000_0012, 2'd2, 0, 32'h0);
        run_data("st byte3", 1'b1, 32'h0000_2303, 32'h0000_0034, 2'd2, 0, 32'h0);
        run_data("ld byte1", 1'b0, 32'h0000_2401, 32'h0, 2'd2, 4, 32'h8765_4321);

        run_illegal("word misaligned", 32'h0000_3001, 2'd0);
        run_illegal("half misaligned", 32'h0000_3003, 2'd1);
        run_illegal("size 3", 32'h0000_3000, 2'd3);

        // Ack while idle must be ignored.
        bus.memAck = 1'b1; bus.memRdata = 32'h1111_2222;
        @(negedge clk);
        bus.memAck = 1'b0;
        chk("idle ack no done", 32'(bus.ifDone | bus.dDone | bus.memReq), 32'd0);
        @(negedge clk);
        chk("idle ack still quiet", 32'(bus.ifDone | bus.dDone | bus.memReq), 32'd0);

        // Fetch timeout: memReq high for MAX_WAIT cycles, then ifErr.
        set_expect(1'b1, 1'b0, 32'h0000_7000, '0, 2'd0);
        bus.ifReq = 1'b1; bus.ifAddr = 32'h0000_7000;
        n = 0;
        @(negedge clk);
        while (bus.memReq && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout memReq cycles", 32'(n), 32'd15);
        chk("timeout ifErr", 32'(bus.ifErr), 32'd1);
        chk("timeout ifDone", 32'(bus.ifDone), 32'd0);
        exp_valid = 1'b0;
        bus.ifReq = 1'b0;
        @(negedge clk);
        chk("timeout ifErr cleared", 32'(bus.ifErr), 32'd0);
        @(negedge clk);
        chk("timeout idle", 32'(bus.memReq), 32'd0);

        // Reset in the middle of a data access aborts it silently.
        set_expect(1'b0, 1'b1, 32'h0000_6003, 32'h0000_0077, 2'd2);
        bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 32'h0000_6003; bus.dWdata = 32'h77; bus.dSize = 2'd2;
        @(negedge clk);
        chk("pre-reset memReq", 32'(bus.memReq), 32'd1);
        rst_n = 1'b0; bus.dReq = 1'b0; exp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort memReq", 32'(bus.memReq), 32'd0);
        chk("abort pulses", 32'({bus.dDone, bus.dErr, bus.ifDone, bus.ifErr}), 32'd0);
        chk("abort dOffset", 32'(bus.dOffset), 32'd0);
        @(negedge clk);
        chk("after abort quiet", 32'({bus.dDone, bus.dErr, bus.memReq}), 32'd0);
        run_data("post-reset load", 1'b0, 32'h0000_6000, 32'h0, 2'd0, 1, 32'h600D_600D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, word-wide data memory between the instruction-fetch port and the load/store port of the CPU.
- Arbitrates between the two ports and sequences each access through a req/ack handshake with timeout.
- For stores, formats byte lanes and byte enables (big-endian: offset 0 = bits 31:24).
- For loads, returns the raw word plus registered offset/size, which feed the load-data extraction logic.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- MAX_WAIT, 15, cycles to wait for memAck before aborting; range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- ifReq  in  1  fetch request; held until ifDone/ifErr
- ifAddr  in  ADDR_W  fetch address; low 2 bits ignored
- ifRdata  out  32  fetched word; valid while ifDone=1
- ifDone  out  1  one-cycle completion pulse
- ifErr  out  1  one-cycle timeout pulse
- dReq  in  1  data request; held until dDone/dErr
- dWe  in  1  1 store, 0 load
- dAddr  in  ADDR_W  byte address
- dWdata  in  32  store data, right-justified
- dSize  in  2  0 word, 1 half, 2 byte, 3 illegal
- dRdata  out  32  raw memory word; valid while dDone=1
- dOffset  out  2  dAddr[1:0] of the completed access
- dSizeQ  out  2  dSize of the completed access
- dDone  out  1  one-cycle completion pulse
- dErr  out  1  one-cycle misalign/illegal/timeout pulse
- memReq  out  1  memory request
- memWe  out  1  memory write
- memAddr  out  ADDR_W  word-aligned address; low 2 bits = 0
- memWdata  out  32  lane-formatted store data
- memBe  out  4  byte enables; bit3 = bits 31:24
- memRdata  in  32  memory read data; valid with memAck
- memAck  in  1  memory completion
- stall  out  1  high while any port has an uncompleted request

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE; lastGrant = FETCH.
  - All outputs clear to 0: memReq, memWe, memAddr, memWdata, memBe, all done/err pulses, dOffset, dSizeQ, ifRdata, dRdata.
  - Reset mid-transaction aborts the access. No done/err pulse is issued. memReq is low after that edge.
- FSM states: IDLE, FETCH, DATA, RESP.
- IDLE:
  - Only fetch requests: go to FETCH.
  - Only data requests: legality check first.
  - Both request: grant the port not equal to lastGrant (the first conflict after reset goes to data), then update lastGrant.
- Data legality:
  - Illegal when dSize=3, half with offset bit0=1, or word with offset≠0.
  - Illegal request: dErr pulses the next cycle. No memory access. FSM stays in IDLE/RESP path. dOffset and dSizeQ are still loaded.
- Entering FETCH or DATA:
  - Register memAddr, memWe, memWdata, memBe, dOffset, dSizeQ.
  - Assert memReq on the next cycle. memReq and its qualifiers stay stable until ack or timeout.
  - Fetch uses memWe=0 and memBe=1111.
- Byte lanes:
  - Word: memBe=1111, memWdata=dWdata.
  - Half, offset 0: memBe=1100. Half, offset 2: memBe=0011. memWdata={dWdata[15:0],dWdata[15:0]}.
  - Byte, offset k: memBe = one-hot, bit(3-k). memWdata = dWdata[7:0] replicated in all four lanes.
  - Loads also drive the computed memBe.
- Wait counter:
  - Cleared on grant; increments each cycle memReq=1 and memAck=0.
  - On reaching MAX_WAIT: drop memReq, pulse the owning port's err, go to IDLE.
- memAck handling:
  - With memAck=1 in FETCH/DATA: drop memReq next cycle, latch memRdata into ifRdata/dRdata, go to RESP.
  - RESP pulses done for exactly one cycle, then returns to IDLE.
- Latency: grant edge T → memReq high at T+1 → ack at T+1+k → done at T+2+k. Minimum 3 cycles from request to done.
- memAck while in IDLE or RESP is ignored.
- A requester dropping its req mid-transaction does not cancel the access; done still pulses.
- A requester must hold its request inputs stable until done/err. The block samples them only at grant.
- stall = (ifReq or dReq) and not (the done/err for that request this cycle).

Decomposition:
- Package mem_pkg:
  - Size encodings SZ_WORD=0, SZ_HALF=1, SZ_BYTE=2.
  - FSM state enum and grant enum {FETCH, DATA}.
  - Function for the misalignment check.
- One combinational sub-module, store_lane_formatter: inputs size, offset, wdata; outputs be, laneData. Shared by the store path and used for directed unit tests.

Test Plan:
- Store byte dAddr=0x1002, dWdata=0x000000AB → memAddr=0x1000, memBe=0010, memWdata=0xABABABAB, memWe=1; ack after 2 cycles → dDone 1 cycle later.
- Load half dAddr=0x2002, memRdata=0x1234ABCD with ack → dRdata=0x1234ABCD, dOffset=2, dSizeQ=1, dDone single pulse.
- ifReq and dReq rise together after reset → data served first, then fetch; repeat the conflict → fetch served first (alternation).
- Word at dAddr=0x3001, then half at 0x3003 → dErr pulse each, memReq never asserted.
- Fetch with memAck held low, MAX_WAIT=15 → memReq high exactly 15 cycles, then ifErr pulse, FSM returns to IDLE.
- rst_n=0 for one edge while in DATA → memReq=0 after that edge, no dDone/dErr, a new request is then served normally.
